// File: rtl/arc_drawer_if.sv
// Request/response and VGA plot bundle between a shape sequencer and arc_drawer.
// Optional ARC_PIXCNT_EN adds the pix_count statistics output.
interface arc_drawer_if #(
  parameter int unsigned X_W = 8,
  parameter int unsigned Y_W = 7,
  parameter int unsigned R_W = 8
);

  logic           start;
  logic [X_W-1:0] centre_x;
  logic [Y_W-1:0] centre_y;
  logic [R_W-1:0] radius;
  logic [2:0]     colour;
  logic [7:0]     octant_mask;
  logic           done;
  logic [X_W-1:0] vga_x;
  logic [Y_W-1:0] vga_y;
  logic [2:0]     vga_colour;
  logic           vga_plot;
`ifdef ARC_PIXCNT_EN
  logic [15:0]    pix_count;
`endif

  modport master (
    output start, centre_x, centre_y, radius, colour, octant_mask,
    input  done, vga_x, vga_y, vga_colour, vga_plot
`ifdef ARC_PIXCNT_EN
    , input pix_count
`endif
  );

  modport slave (
    input  start, centre_x, centre_y, radius, colour, octant_mask,
    output done, vga_x, vga_y, vga_colour, vga_plot
`ifdef ARC_PIXCNT_EN
    , output pix_count
`endif
  );

endinterface

// File: rtl/arc_drawer.sv
// Midpoint circle / arc drawer: one cycle per octant, octant mask plus screen clipping.
// Define ARC_PIXCNT_EN to add a saturating count of plotted pixels (pix_count).
module arc_drawer #(
  parameter int unsigned X_W      = 8,
  parameter int unsigned Y_W      = 7,
  parameter int unsigned R_W      = 8,
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120
) (
  input  logic       clk,
  input  logic       rst_n,
  arc_drawer_if.slave bus
);

  localparam int unsigned XyW = (X_W > Y_W) ? X_W : Y_W;
  localparam int unsigned CW  = ((XyW > R_W) ? XyW : R_W) + 2;
  localparam int unsigned KW  = R_W + 3;

  localparam logic signed [CW-1:0] ScrW = CW'(SCREEN_W);
  localparam logic signed [CW-1:0] ScrH = CW'(SCREEN_H);
  localparam logic signed [KW-1:0] KOne = KW'(1);

  typedef enum logic [1:0] {StIdle, StPlot, StDone} state_e;

  state_e state_q, state_d;

  logic [X_W-1:0]        cx_q, cx_d;
  logic [Y_W-1:0]        cy_q, cy_d;
  logic [R_W-1:0]        ox_q, ox_d;
  logic [R_W-1:0]        oy_q, oy_d;
  logic signed [KW-1:0]  crit_q, crit_d;
  logic [2:0]            oct_q, oct_d;
  logic [2:0]            colour_q, colour_d;
  logic [7:0]            mask_q, mask_d;

  logic                  start_draw;
  logic                  plot_en;
  logic                  last_iter;

  logic signed [KW-1:0]  rad_k, ox_k, oy_k, ox_n, oy_n, crit_n;
  logic                  crit_le0;
  logic signed [CW-1:0]  cx_s, cy_s, ox_s, oy_s, x_c, y_c;

  assign start_draw = (state_q == StIdle) && bus.start;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (bus.start) state_d = StPlot;
      StPlot:  if ((oct_q == 3'd7) && last_iter) state_d = StDone;
      StDone:  if (!bus.start) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    bus.done       = 1'b0;
    bus.vga_plot   = 1'b0;
    bus.vga_x      = '0;
    bus.vga_y      = '0;
    bus.vga_colour = '0;
    case (state_q)
      StPlot: begin
        bus.vga_plot   = plot_en;
        bus.vga_x      = x_c[X_W-1:0];
        bus.vga_y      = y_c[Y_W-1:0];
        bus.vga_colour = colour_q;
      end
      StDone:  bus.done = 1'b1;
      default: ;
    endcase
  end

  // Midpoint step; values widened so ox may go to -1 when radius is 0.
  assign rad_k    = signed'({3'b000, bus.radius});
  assign ox_k     = signed'({3'b000, ox_q});
  assign oy_k     = signed'({3'b000, oy_q});
  assign crit_le0 = crit_q[KW-1] || (crit_q == '0);

  always_comb begin
    oy_n = oy_k + KOne;
    ox_n = ox_k;
    if (crit_le0) begin
      crit_n = crit_q + (oy_n <<< 1) + KOne;
    end else begin
      ox_n   = ox_k - KOne;
      crit_n = crit_q + ((oy_n - ox_n) <<< 1) + KOne;
    end
  end

  assign last_iter = oy_n > ox_n;

  // Candidate pixel for the current octant index
  assign cx_s = signed'({{(CW - X_W){1'b0}}, cx_q});
  assign cy_s = signed'({{(CW - Y_W){1'b0}}, cy_q});
  assign ox_s = signed'({{(CW - R_W){1'b0}}, ox_q});
  assign oy_s = signed'({{(CW - R_W){1'b0}}, oy_q});

  always_comb begin
    x_c = cx_s;
    y_c = cy_s;
    case (oct_q)
      3'd0: begin x_c = cx_s + ox_s; y_c = cy_s + oy_s; end
      3'd1: begin x_c = cx_s + oy_s; y_c = cy_s + ox_s; end
      3'd2: begin x_c = cx_s - oy_s; y_c = cy_s + ox_s; end
      3'd3: begin x_c = cx_s - ox_s; y_c = cy_s + oy_s; end
      3'd4: begin x_c = cx_s - ox_s; y_c = cy_s - oy_s; end
      3'd5: begin x_c = cx_s - oy_s; y_c = cy_s - ox_s; end
      3'd6: begin x_c = cx_s + oy_s; y_c = cy_s - ox_s; end
      3'd7: begin x_c = cx_s + ox_s; y_c = cy_s - oy_s; end
    endcase
  end

  assign plot_en = mask_q[oct_q] && !x_c[CW-1] && (x_c < ScrW) && !y_c[CW-1] && (y_c < ScrH);

  // Datapath next-state
  always_comb begin
    cx_d     = cx_q;
    cy_d     = cy_q;
    ox_d     = ox_q;
    oy_d     = oy_q;
    crit_d   = crit_q;
    oct_d    = oct_q;
    colour_d = colour_q;
    mask_d   = mask_q;
    if (start_draw) begin
      cx_d     = bus.centre_x;
      cy_d     = bus.centre_y;
      ox_d     = bus.radius;
      oy_d     = '0;
      crit_d   = KOne - rad_k;
      oct_d    = '0;
      colour_d = bus.colour;
      mask_d   = bus.octant_mask;
    end else if (state_q == StPlot) begin
      oct_d = oct_q + 3'd1;
      if (oct_q == 3'd7) begin
        oy_d   = oy_n[R_W-1:0];
        ox_d   = ox_n[R_W-1:0];
        crit_d = crit_n;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cx_q     <= '0;
      cy_q     <= '0;
      ox_q     <= '0;
      oy_q     <= '0;
      crit_q   <= '0;
      oct_q    <= '0;
      colour_q <= '0;
      mask_q   <= '0;
    end else begin
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      ox_q     <= ox_d;
      oy_q     <= oy_d;
      crit_q   <= crit_d;
      oct_q    <= oct_d;
      colour_q <= colour_d;
      mask_q   <= mask_d;
    end
  end

`ifdef ARC_PIXCNT_EN
  logic [15:0] pix_cnt_q, pix_cnt_d;

  always_comb begin
    pix_cnt_d = pix_cnt_q;
    if (start_draw) begin
      pix_cnt_d = '0;
    end else if (bus.vga_plot && (pix_cnt_q != 16'hFFFF)) begin
      pix_cnt_d = pix_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix_cnt_q <= '0;
    end else begin
      pix_cnt_q <= pix_cnt_d;
    end
  end

  assign bus.pix_count = pix_cnt_q;
`endif

endmodule

// File: doc/arc_drawer.md
Name: arc_drawer

Overview:
- Parametrised successor to the fixed single-circle drawer used by the shape tasks.
- Draws a midpoint (Bresenham) circle or any subset of its eight octants, selected by a mask.
  - Subsets give arcs, which compose into Reuleaux triangles and similar shapes without per-shape RTL.
- Handles arbitrary screen size and coordinate widths; clips to the screen.
- Sits between a shape sequencer and the VGA adaptor's plot interface.

Parameters:
- X_W, 8, width of x coordinates (centre_x, vga_x).
- Y_W, 7, width of y coordinates (centre_y, vga_y).
- R_W, 8, width of radius.
- SCREEN_W, 160, visible columns; a pixel is plotted only if x < SCREEN_W.
- SCREEN_H, 120, visible rows; a pixel is plotted only if y < SCREEN_H.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, synchronous active-low reset.
- start, input, 1, request to draw; level, held until done is seen.
- centre_x, input, X_W, centre column; sampled on start.
- centre_y, input, Y_W, centre row; sampled on start.
- radius, input, R_W, radius; sampled on start.
- colour, input, 3, pixel colour; sampled on start.
- octant_mask, input, 8, per-octant enable; sampled on start.
- done, output, 1, drawing complete.
- vga_x, output, X_W, pixel column.
- vga_y, output, Y_W, pixel row.
- vga_colour, output, 3, pixel colour.
- vga_plot, output, 1, write strobe for the current pixel.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous, active-low (rst_n).
- Reset values: state=IDLE; done, vga_plot, vga_x, vga_y and vga_colour are all 0. Reset mid-draw aborts to IDLE on the next edge.
- States:
  - IDLE -> PLOT on a clock edge with start=1.
  - PLOT -> DONE after the last octant cycle of the final iteration.
  - DONE -> IDLE when start=0.
- Capture: on IDLE->PLOT, latch centre, radius, colour and mask, then initialise:
  - ox = radius
  - oy = 0
  - crit = 1 - radius, signed, R_W+3 bits
  - oct = 0
- Input changes while not in IDLE are ignored.
- PLOT takes one cycle per octant index oct=0..7. Candidate pixel for each index:
  - 0: (cx+ox, cy+oy)
  - 1: (cx+oy, cy+ox)
  - 2: (cx-oy, cy+ox)
  - 3: (cx-ox, cy+oy)
  - 4: (cx-ox, cy-oy)
  - 5: (cx-oy, cy-ox)
  - 6: (cx+oy, cy-ox)
  - 7: (cx+ox, cy-oy)
- Candidate arithmetic is signed, max(X_W,R_W)+2 bits. vga_x/vga_y carry the low X_W/Y_W bits.
- vga_plot=1 in that cycle only if octant_mask[oct]=1 and 0 <= x < SCREEN_W and 0 <= y < SCREEN_H. Otherwise vga_plot=0 and the cycle is still consumed.
  - Cycle count is therefore independent of mask and clipping.
- vga_colour = latched colour throughout PLOT.
- Iteration update, on the edge leaving oct=7:
  - oy <= oy+1.
  - If crit <= 0: crit <= crit + 2*(oy+1) + 1.
  - Else: ox <= ox-1 and crit <= crit + 2*((oy+1)-(ox-1)) + 1.
  - If the new oy > new ox, go to DONE; else oct wraps to 0 and PLOT continues.
- Latency: the first pixel is presented in the cycle after the start-sampling edge. Total PLOT cycles = 8 x iteration count.
- DONE: done=1 and vga_plot=0, held until start=0. done drops in the cycle after start is seen low.
  - Back-to-back draws need start low for at least one cycle.
- radius=0: one iteration; all eight cycles present (cx,cy); duplicate plots permitted.

Optional Feature:
- Macro: ARC_PIXCNT_EN.
- When defined: adds output pix_count (16 bits).
  - Cleared on IDLE->PLOT.
  - Increments on every cycle with vga_plot=1; saturates at 16'hFFFF.
  - Holds its value through DONE and IDLE until the next start; reset value 0.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: rst_n=0 for 3 cycles -> state IDLE, done=0, vga_plot=0, vga_x=0, vga_y=0.
- Start centre (80,60), r=0, mask 8'hFF -> 8 cycles of vga_plot=1 at (80,60); done=1 in the 9th cycle after the start edge; start=0 -> done=0 and IDLE next cycle.
- Start centre (80,60), r=1, mask 8'hFF:
  - 16 PLOT cycles, then done.
  - First iteration: (81,60), (80,61), (80,61), (79,60), (79,60), (80,59), (80,59), (81,60).
  - Second iteration: (81,61) and symmetric points.
- Start centre (80,60), r=40, mask 8'h01 -> vga_plot=1 only when oct=0; total cycle count equals the mask 8'hFF run; all plotted pixels satisfy x>=80 and y>=60.
- Start centre (0,0), r=10, mask 8'hFF -> (10,0) plotted; (-10,0) and (0,-10) cycles have vga_plot=0; no plotted x>=160 or y>=120. With ARC_PIXCNT_EN, pix_count equals the plotted count.
- Assert rst_n=0 mid-PLOT with r=80 -> IDLE and vga_plot=0 on the next edge; a fresh start after release draws correctly from oy=0.
